// File: rtl/gpnae_mc.sv
// Multi-channel fixed-point activation engine: per-channel saturating accumulators, one
// registered activation stage and a first-word-fall-through result FIFO.
module gpnae_mc #(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned FRAC_BITS   = 8,
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned GUARD_BITS  = 5,
  parameter int unsigned FIFO_ADDR   = 3,
  parameter int unsigned LEAKY_SHIFT = 3,
  parameter logic [DATA_WIDTH-1:0] LAMBDA_Q = 16'h010D,
  parameter logic [DATA_WIDTH-1:0] LA_Q     = 16'h01C2,
  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic [CH_W-1:0]       in_ch_i,
  input  logic                  in_last_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic                  cfg_we_i,
  input  logic [CH_W-1:0]       cfg_ch_i,
  input  logic [2:0]            cfg_mode_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic [CH_W-1:0]       out_ch_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [NUM_CH-1:0]     sat_o,
  output logic                  busy_o
);

  localparam int unsigned ACC_W  = DATA_WIDTH + GUARD_BITS;
  localparam int unsigned PROD_W = ACC_W + DATA_WIDTH;
  localparam int unsigned DEPTH  = 2 ** FIFO_ADDR;
  localparam logic signed [PROD_W-1:0] ONE_W    = PROD_W'(1) << FRAC_BITS;
  localparam logic signed [PROD_W-1:0] LAM_W    = {{ACC_W{LAMBDA_Q[DATA_WIDTH-1]}}, LAMBDA_Q};
  localparam logic signed [PROD_W-1:0] LA_W     = {{ACC_W{LA_Q[DATA_WIDTH-1]}}, LA_Q};
  localparam logic signed [PROD_W-1:0] NEG_LA_W = -LA_W;
  localparam logic signed [PROD_W-1:0] NEG_ONE  = -ONE_W;

  logic signed [ACC_W-1:0]  acc_q [NUM_CH];
  logic [2:0]               mode_q [NUM_CH];
  logic [NUM_CH-1:0]        open_q, sat_q, sat_set;
  logic                     b_valid_q;
  logic [CH_W-1:0]          b_ch_q;
  logic [2:0]               b_mode_q;
  logic signed [ACC_W-1:0]  b_sum_q;
  logic [DATA_WIDTH-1:0]    fifo_data_q [DEPTH];
  logic [CH_W-1:0]          fifo_ch_q [DEPTH];
  logic [FIFO_ADDR-1:0]     wptr_q, rptr_q;
  logic [FIFO_ADDR:0]       cnt_q;

  logic                     in_ch_ok, cfg_ch_ok, in_fire, fifo_full, push, pop;
  logic signed [ACC_W-1:0]  acc_cur, acc_sum;
  logic [ACC_W:0]           sum_ext;
  logic                     acc_ovf;
  logic signed [PROD_W-1:0] x_w, prod_l, prod_la, tmp;
  logic [DATA_WIDTH:0]      sat_x;
  logic [DATA_WIDTH-1:0]    res_d;
  logic                     res_sat;

  // Returns {overflow, clamped value}.
  function automatic logic [DATA_WIDTH:0] sat_dw(input logic signed [PROD_W-1:0] v);
    if (v[PROD_W-1:DATA_WIDTH-1] == {(PROD_W-DATA_WIDTH+1){v[PROD_W-1]}}) begin
      return {1'b0, v[DATA_WIDTH-1:0]};
    end
    return {1'b1, v[PROD_W-1], {(DATA_WIDTH-1){~v[PROD_W-1]}}};
  endfunction

  assign in_ch_ok   = int'(in_ch_i) < int'(NUM_CH);
  assign cfg_ch_ok  = int'(cfg_ch_i) < int'(NUM_CH);
  // Room is counted for the stage B entry too, so a new last beat never overwrites it.
  assign in_ready_o = ~rst_i & ((int'(cnt_q) + int'(b_valid_q)) < int'(DEPTH));
  assign in_fire    = in_valid_i & in_ready_o & in_ch_ok;
  assign fifo_full  = (cnt_q == (FIFO_ADDR + 1)'(DEPTH));
  assign out_valid_o = (cnt_q != '0);
  assign pop        = out_valid_o & out_ready_i;
  assign push       = b_valid_q & (~fifo_full | pop);
  assign out_data_o = out_valid_o ? fifo_data_q[rptr_q] : '0;
  assign out_ch_o   = out_valid_o ? fifo_ch_q[rptr_q] : '0;
  assign sat_o      = sat_q;
  assign busy_o     = (|open_q) | b_valid_q | out_valid_o;

  always_comb begin
    acc_cur = acc_q[in_ch_i];
    sum_ext = {acc_cur[ACC_W-1], acc_cur}
            + {{(GUARD_BITS + 1){in_data_i[DATA_WIDTH-1]}}, in_data_i};
    acc_ovf = sum_ext[ACC_W] ^ sum_ext[ACC_W-1];
    acc_sum = acc_ovf ? {sum_ext[ACC_W], {(ACC_W-1){~sum_ext[ACC_W]}}} : sum_ext[ACC_W-1:0];
  end

  always_comb begin
    x_w     = {{DATA_WIDTH{b_sum_q[ACC_W-1]}}, b_sum_q};
    prod_l  = x_w * LAM_W;
    prod_la = x_w * LA_W;
    sat_x   = sat_dw(x_w);
    tmp     = '0;
    res_d   = sat_x[DATA_WIDTH-1:0];
    res_sat = sat_x[DATA_WIDTH];
    case (b_mode_q)
      3'd1: if (x_w < 0) begin
        res_d   = '0;
        res_sat = 1'b0;
      end
      3'd2: if (x_w < 0) {res_sat, res_d} = sat_dw(x_w >>> LEAKY_SHIFT);
      3'd3: begin
        tmp     = (x_w >>> 2) + (ONE_W >>> 1);
        res_sat = 1'b0;
        if (tmp < 0)          res_d = '0;
        else if (tmp > ONE_W) res_d = ONE_W[DATA_WIDTH-1:0];
        else                  res_d = tmp[DATA_WIDTH-1:0];
      end
      3'd4: begin
        res_sat = 1'b0;
        if (x_w < NEG_ONE)    res_d = NEG_ONE[DATA_WIDTH-1:0];
        else if (x_w > ONE_W) res_d = ONE_W[DATA_WIDTH-1:0];
        else                  res_d = x_w[DATA_WIDTH-1:0];
      end
      3'd5: if (x_w >= 0) begin
        {res_sat, res_d} = sat_dw(prod_l >>> FRAC_BITS);
      end else begin
        tmp     = prod_la >>> FRAC_BITS;
        res_sat = 1'b0;
        res_d   = (tmp < NEG_LA_W) ? NEG_LA_W[DATA_WIDTH-1:0] : tmp[DATA_WIDTH-1:0];
      end
      default: ;
    endcase
  end

  always_comb begin
    sat_set = '0;
    if (in_fire && acc_ovf) sat_set[in_ch_i] = 1'b1;
    if (push && res_sat)    sat_set[b_ch_q]  = 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(NUM_CH); i++) begin
        acc_q[i]  <= '0;
        mode_q[i] <= '0;
      end
      open_q    <= '0;
      sat_q     <= '0;
      b_valid_q <= 1'b0;
      b_ch_q    <= '0;
      b_mode_q  <= '0;
      b_sum_q   <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      cnt_q     <= '0;
    end else begin
      sat_q <= sat_q | sat_set;
      if (cfg_we_i && cfg_ch_ok) mode_q[cfg_ch_i] <= cfg_mode_i;
      if (in_fire) begin
        if (in_last_i) begin
          acc_q[in_ch_i]  <= '0;
          open_q[in_ch_i] <= 1'b0;
          b_ch_q          <= in_ch_i;
          b_mode_q        <= mode_q[in_ch_i];
          b_sum_q         <= acc_sum;
        end else begin
          acc_q[in_ch_i]  <= acc_sum;
          open_q[in_ch_i] <= 1'b1;
        end
      end
      if (in_fire && in_last_i) b_valid_q <= 1'b1;
      else if (push)            b_valid_q <= 1'b0;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      if (push && !pop)      cnt_q <= cnt_q + 1'b1;
      else if (!push && pop) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_data_q[wptr_q] <= res_d;
      fifo_ch_q[wptr_q]   <= b_ch_q;
    end
  end

endmodule
